// File: rtl/ee357_sign_extend_16_to_32.sv
// ee357_sign_extend_16_to_32: combinational sign extension plus registered extend/shift path
module ee357_sign_extend_16_to_32 #(
  parameter int SHIFT_AMT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  output logic [31:0] out,
  input  logic        in_valid,
  input  logic        zext,
  output logic [31:0] out_q,
  output logic [31:0] out_q_shl,
  output logic        out_valid
);
  logic [31:0] ext;
  // zero-latency sign extension, independent of the registered path
  always_comb out = {{16{in[15]}}, in};
  // mode-selected extension feeding the capture registers
  always_comb ext = zext ? {16'h0000, in} : {{16{in[15]}}, in};
  // capture on in_valid; reset wins and clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_q_shl <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q     <= ext;
        out_q_shl <= ext << SHIFT_AMT;
      end
    end
  end
endmodule

// File: tb/tb_ee357_sign_extend_16_to_32.sv
// tb_ee357_sign_extend_16_to_32: randomized and directed checks against an arithmetic reference model
module tb_ee357_sign_extend_16_to_32;
  localparam int SHIFT = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in = '0;
  logic [31:0] out;
  logic        in_valid = 1'b0;
  logic        zext = 1'b0;
  logic [31:0] out_q;
  logic [31:0] out_q_shl;
  logic        out_valid;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q = '0;
  logic [31:0] exp_shl = '0;
  logic        exp_v = 1'b0;

  ee357_sign_extend_16_to_32 #(.SHIFT_AMT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .in_valid(in_valid),
    .zext(zext), .out_q(out_q), .out_q_shl(out_q_shl), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sx(input logic [15:0] d);
    longint s;
    s = (longint'(d) >= 32768) ? longint'(d) - 65536 : longint'(d);
    return 32'(s);
  endfunction

  function automatic logic [31:0] shl(input logic [31:0] e);
    return 32'(longint'(e) * (longint'(1) << SHIFT));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic z, input logic [15:0] d);
    logic [31:0] e;
    rst = r; in_valid = v; zext = z; in = d;
    @(posedge clk);
    e = z ? {16'h0, d} : sx(d);
    if (r) begin
      exp_q = '0; exp_shl = '0; exp_v = 1'b0;
    end else begin
      exp_v = v;
      if (v) begin
        exp_q = e; exp_shl = shl(e);
      end
    end
    #1;
    check("out", out, sx(d));
    check("out_q", out_q, exp_q);
    check("out_q_shl", out_q_shl, exp_shl);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
  endtask

  initial begin
    in = 16'h8001;
    #1 check("comb_8001", out, 32'hFFFF8001);
    in = 16'h0003;
    #1 check("comb_0003", out, 32'h00000003);
    in = 16'h7FFF;
    #1 check("comb_7fff", out, 32'h00007FFF);
    in = 16'hFFFF;
    #1 check("comb_ffff", out, 32'hFFFFFFFF);
    step(1, 0, 0, 16'h0000);
    step(0, 1, 0, 16'h8001);
    check("d_sx_q", out_q, 32'hFFFF8001);
    check("d_sx_shl", out_q_shl, 32'hFFFE0004);
    step(0, 1, 1, 16'h8001);
    check("d_zx_q", out_q, 32'h00008001);
    check("d_zx_shl", out_q_shl, 32'h00020004);
    step(0, 0, 0, 16'h1234);
    check("d_hold_q", out_q, 32'h00008001);
    check("d_hold_v", {31'b0, out_valid}, 32'h0);
    step(1, 1, 0, 16'h7777);
    check("d_rst_q", out_q, 32'h0);
    step(0, 1, 0, 16'h7FFF);
    check("b_7fff", out_q, 32'h00007FFF);
    step(0, 1, 0, 16'h8000);
    check("b_8000", out_q, 32'hFFFF8000);
    step(0, 1, 0, 16'hFFFF);
    check("b_ffff_s", out_q, 32'hFFFFFFFF);
    step(0, 1, 1, 16'hFFFF);
    check("b_ffff_z", out_q, 32'h0000FFFF);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom));
    in_valid = 1'b0; rst = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      int f;
      f = n_fail;
      in = 16'(i);
      #1 check("sweep", out, sx(16'(i)));
      if (n_fail != f) break;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
